instr_encoder: RTL and testbench
================================

Name: instr_encoder

Overview:
- Inverse of the datapath control decode. Takes an abstract ALU operation (alu_ctrl code, alu_src select, register indices, immediate) and emits the 32-bit RV32I R-type or I-type instruction word that decodes back to those control signals.
- Each emitted word carries a write address into instruction memory. The block is used by the on-chip program loader and by self-checking testbenches that generate instruction streams.
- Valid/ready on both sides, one registered output stage, a wrapping address counter, and error/full flags.

Parameters:
- ADDR_W, 8, width of the instruction-memory word address.
- DEPTH, 256, number of words in instruction memory; must be ≤ 2^ADDR_W and ≥ 2.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  request valid.
- in_ready  out  1  block accepts a request this cycle.
- in_alu_ctrl  in  4  operation code: 0000 add, 0001 sub, 0010 sll, 0011 slt, 0100 xor, 0101 srl, 0110 or, 0111 and.
- in_alu_src  in  1  0 selects R-type (rs2), 1 selects I-type (immediate).
- in_rd  in  5  destination register.
- in_rs1  in  5  source register 1.
- in_rs2  in  5  source register 2; ignored when in_alu_src=1.
- in_imm  in  12  immediate; ignored when in_alu_src=0.
- out_valid  out  1  out_instr/out_addr valid.
- out_ready  in  1  consumer accepts the word.
- out_instr  out  32  encoded instruction.
- out_addr  out  ADDR_W  instruction-memory word address for out_instr.
- err  out  1  sticky: an illegal request was consumed.
- full  out  1  sticky: DEPTH words have been emitted.
- clear  in  1  synchronous; resets the address counter, err and full.

Behaviour:
- Reset (rst_n=0, async): out_valid=0, out_instr=0, out_addr=0, err=0, full=0. The internal address counter is 0.
- Acceptance: in_ready = !full && (!out_valid || out_ready). A request is taken when in_valid && in_ready.
- Latency: exactly 1 cycle. An accepted legal request appears on out_valid/out_instr the next cycle.
- Output hold: out_instr and out_addr stay stable while out_valid && !out_ready. Back-to-back throughput is 1 word/cycle.
- R-type word (in_alu_src=0): {funct7, rs2, rs1, funct3, rd, 7'b0110011}.
  - funct7 = 0100000 for sub, 0000000 otherwise.
- I-type word (in_alu_src=1): {imm[11:0], rs1, funct3, rd, 7'b0010011}.
  - For sll/srl the upper field is {7'b0000000, imm[4:0]}.
- funct3: add/sub 000, sll 001, slt 010, xor 100, srl 101, or 110, and 111.
- Illegal requests, in priority order, are all consumed (handshake completes) but produce no output word and set err:
  - alu_ctrl ≥ 1000;
  - sub with alu_src=1;
  - sll/srl with alu_src=1 and imm[11:5] ≠ 0.
- Address: out_addr is taken from the counter when the word is loaded into the output register. The counter increments on each legal acceptance.
- Wrap and full: loading a word at counter DEPTH-1 wraps the counter to 0 and sets full.
  - While full=1, in_ready=0. A pending output word still drains normally.
- clear: takes priority over a same-cycle acceptance; the request is not accepted that cycle (in_ready forced 0).
  - Counter, err and full go to 0. A pending output word is kept and still drains.
- Simultaneous acceptance and drain in the same cycle: the new word replaces the old one; no bubble.
- Reset mid-transfer: the pending word is discarded and out_valid drops immediately.
- No combinational path from out_ready to out_valid. in_ready depends combinationally on out_ready.

Decomposition:
- Shared package holds:
  - opcode constants OP_RTYPE=0110011 and OP_ITYPE=0010011;
  - the funct3 constants;
  - FUNCT7_SUB=0100000;
  - the ALU_* 4-bit codes, so the control decoder and this block share one definition.
- One combinational sub-module, instr_pack: request fields → {instr[31:0], illegal}.
- The top level holds the output register, the handshake, the counter and the flags.

Test Plan:
- addi x1,x0,5 (ctrl 0000, src 1, rd 1, rs1 0, imm 5), out_ready=1 → next cycle out_instr=0x00500093, out_addr=0.
- sub x3,x1,x2 then add x3,x1,x2 back-to-back → 0x402081B3 @addr 0, then 0x002081B3 @addr 1; in_ready stays 1 throughout.
- slli x5,x5,3 with out_ready=0 for 3 cycles → 0x00329293 held stable, in_ready=0; word transfers when out_ready rises.
- slli with imm=0x020, ctrl 1000, and subi requests → each is consumed, no out_valid, err=1, counter unchanged; clear → err=0.
- DEPTH=4: emit 4 legal words → addrs 0..3, full=1, in_ready=0; clear → addr restarts at 0.
- Assert rst_n low while out_valid=1 and out_ready=0 → out_valid=0 immediately; outputs 0 after release.

Source files
------------

// File: rtl/instr_encoder_pkg.sv
// Shared RV32I ALU encoding constants and request type for the encoder and
// the datapath control decoder.
package instr_encoder_pkg;

  localparam logic [6:0] OP_RTYPE   = 7'b0110011;
  localparam logic [6:0] OP_ITYPE   = 7'b0010011;
  localparam logic [6:0] FUNCT7_SUB = 7'b0100000;

  localparam logic [2:0] F3_ADD = 3'b000;
  localparam logic [2:0] F3_SLL = 3'b001;
  localparam logic [2:0] F3_SLT = 3'b010;
  localparam logic [2:0] F3_XOR = 3'b100;
  localparam logic [2:0] F3_SRL = 3'b101;
  localparam logic [2:0] F3_OR  = 3'b110;
  localparam logic [2:0] F3_AND = 3'b111;

  localparam logic [3:0] ALU_ADD = 4'b0000;
  localparam logic [3:0] ALU_SUB = 4'b0001;
  localparam logic [3:0] ALU_SLL = 4'b0010;
  localparam logic [3:0] ALU_SLT = 4'b0011;
  localparam logic [3:0] ALU_XOR = 4'b0100;
  localparam logic [3:0] ALU_SRL = 4'b0101;
  localparam logic [3:0] ALU_OR  = 4'b0110;
  localparam logic [3:0] ALU_AND = 4'b0111;

  typedef struct packed {
    logic [3:0]  alu_ctrl;
    logic        alu_src;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [11:0] imm;
  } enc_req_t;

endpackage

// File: rtl/instr_encoder_pack.sv
// Combinational request -> instruction word packer with legality check.
module instr_pack
  import instr_encoder_pkg::*;
(
  input  enc_req_t    req,
  output logic [31:0] instr,
  output logic        illegal
);

  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [11:0] imm_f;
  logic        is_shift;

  assign is_shift = (req.alu_ctrl == ALU_SLL) || (req.alu_ctrl == ALU_SRL);

  // funct3/funct7 lookup, I-type upper field, and illegal-request priority chain
  always_comb begin
    funct3  = F3_ADD;
    funct7  = 7'b0;
    illegal = 1'b0;
    case (req.alu_ctrl)
      ALU_ADD: funct3 = F3_ADD;
      ALU_SUB: begin funct3 = F3_ADD; funct7 = FUNCT7_SUB; end
      ALU_SLL: funct3 = F3_SLL;
      ALU_SLT: funct3 = F3_SLT;
      ALU_XOR: funct3 = F3_XOR;
      ALU_SRL: funct3 = F3_SRL;
      ALU_OR:  funct3 = F3_OR;
      ALU_AND: funct3 = F3_AND;
      default: funct3 = F3_ADD;
    endcase

    if (req.alu_ctrl[3])
      illegal = 1'b1;
    else if (req.alu_ctrl == ALU_SUB && req.alu_src)
      illegal = 1'b1;
    else if (is_shift && req.alu_src && req.imm[11:5] != 7'b0)
      illegal = 1'b1;

    // shift-immediates carry only shamt; upper 7 bits stay zero (no srai here)
    imm_f = is_shift ? {7'b0, req.imm[4:0]} : req.imm;

    if (req.alu_src)
      instr = {imm_f, req.rs1, funct3, req.rd, OP_ITYPE};
    else
      instr = {funct7, req.rs2, req.rs1, funct3, req.rd, OP_RTYPE};
  end

endmodule

// File: rtl/instr_encoder.sv
// ALU-op -> RV32I instruction encoder with one registered output stage,
// wrapping imem address counter and sticky err/full flags.
module instr_encoder
  import instr_encoder_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int DEPTH  = 256
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        in_alu_ctrl,
  input  logic              in_alu_src,
  input  logic [4:0]        in_rd,
  input  logic [4:0]        in_rs1,
  input  logic [4:0]        in_rs2,
  input  logic [11:0]       in_imm,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_instr,
  output logic [ADDR_W-1:0] out_addr,
  output logic              err,
  output logic              full,
  input  logic              clear
);

  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

  enc_req_t          req;
  logic [31:0]       pk_instr;
  logic              pk_illegal;
  logic [ADDR_W-1:0] cnt;
  logic              accept, load;

  assign req = '{alu_ctrl: in_alu_ctrl, alu_src: in_alu_src, rd: in_rd,
                 rs1: in_rs1, rs2: in_rs2, imm: in_imm};

  instr_pack u_pack (
    .req     (req),
    .instr   (pk_instr),
    .illegal (pk_illegal)
  );

  // clear blocks acceptance so it never races a counter increment
  assign in_ready = !full && !clear && (!out_valid || out_ready);
  assign accept   = in_valid && in_ready;
  assign load     = accept && !pk_illegal;

  // output register: load replaces (even while draining), else drain clears valid
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_instr <= '0;
      out_addr  <= '0;
    end else if (load) begin
      out_valid <= 1'b1;
      out_instr <= pk_instr;
      out_addr  <= cnt;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  // address counter and sticky flags; clear wins over everything else
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt  <= '0;
      err  <= 1'b0;
      full <= 1'b0;
    end else if (clear) begin
      cnt  <= '0;
      err  <= 1'b0;
      full <= 1'b0;
    end else begin
      if (load) begin
        cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
        if (cnt == LAST) full <= 1'b1;
      end
      if (accept && pk_illegal) err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_instr_encoder.sv
// Directed test of instr_encoder (DEPTH=4 so wrap/full is reachable quickly).
module tb_instr_encoder;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [3:0]  in_alu_ctrl = '0;
  logic        in_alu_src = 1'b0;
  logic [4:0]  in_rd = '0, in_rs1 = '0, in_rs2 = '0;
  logic [11:0] in_imm = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] out_instr;
  logic [7:0]  out_addr;
  logic        err, full;
  logic        clear = 1'b0;

  int n_chk = 0;
  int n_fail = 0;

  instr_encoder #(.ADDR_W(8), .DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_alu_ctrl(in_alu_ctrl), .in_alu_src(in_alu_src), .in_rd(in_rd),
    .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm),
    .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
    .out_addr(out_addr), .err(err), .full(full), .clear(clear)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [3:0] c, input logic s, input logic [4:0] rd,
                       input logic [4:0] r1, input logic [4:0] r2, input logic [11:0] im);
    in_alu_ctrl = c; in_alu_src = s; in_rd = rd;
    in_rs1 = r1; in_rs2 = r2; in_imm = im;
    in_valid = 1'b1;
  endtask

  task automatic do_clear();
    clear = 1'b1;
    #1 chk("clr_in_ready", {31'b0, in_ready}, 32'd0);
    step();
    clear = 1'b0;
  endtask

  initial begin
    // reset state
    #2;
    chk("rst_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_instr", out_instr, 32'd0);
    chk("rst_addr",  {24'b0, out_addr}, 32'd0);
    chk("rst_flags", {30'b0, err, full}, 32'd0);
    #10 rst_n = 1'b1;
    step();

    // addi x1,x0,5
    drive(4'b0000, 1'b1, 5'd1, 5'd0, 5'd0, 12'd5);
    #1 chk("addi_in_ready", {31'b0, in_ready}, 32'd1);
    step(); in_valid = 1'b0;
    chk("addi_valid", {31'b0, out_valid}, 32'd1);
    chk("addi_instr", out_instr, 32'h00500093);
    chk("addi_addr",  {24'b0, out_addr}, 32'd0);
    step();
    chk("addi_drain", {31'b0, out_valid}, 32'd0);
    do_clear();

    // sub then add back-to-back
    drive(4'b0001, 1'b0, 5'd3, 5'd1, 5'd2, 12'd0);
    #1 chk("sub_in_ready", {31'b0, in_ready}, 32'd1);
    step();
    chk("sub_instr", out_instr, 32'h402081B3);
    chk("sub_addr",  {24'b0, out_addr}, 32'd0);
    drive(4'b0000, 1'b0, 5'd3, 5'd1, 5'd2, 12'd0);
    #1 chk("add_in_ready", {31'b0, in_ready}, 32'd1);
    step(); in_valid = 1'b0;
    chk("add_valid", {31'b0, out_valid}, 32'd1);
    chk("add_instr", out_instr, 32'h002081B3);
    chk("add_addr",  {24'b0, out_addr}, 32'd1);
    step();
    do_clear();

    // slli x5,x5,3 under backpressure
    out_ready = 1'b0;
    drive(4'b0010, 1'b1, 5'd5, 5'd5, 5'd0, 12'd3);
    step(); in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("slli_hold_valid", {31'b0, out_valid}, 32'd1);
      chk("slli_hold_instr", out_instr, 32'h00329293);
      chk("slli_hold_ready", {31'b0, in_ready}, 32'd0);
      step();
    end
    out_ready = 1'b1;
    #1 chk("slli_release_ready", {31'b0, in_ready}, 32'd1);
    step();
    chk("slli_drained", {31'b0, out_valid}, 32'd0);
    do_clear();

    // illegal requests: consumed, no output, err set, counter unchanged
    drive(4'b0010, 1'b1, 5'd1, 5'd1, 5'd0, 12'h020);
    #1 chk("ill_sll_ready", {31'b0, in_ready}, 32'd1);
    step();
    chk("ill_sll_valid", {31'b0, out_valid}, 32'd0);
    chk("ill_sll_err", {31'b0, err}, 32'd1);
    drive(4'b1000, 1'b0, 5'd1, 5'd1, 5'd2, 12'd0);
    step();
    chk("ill_ctrl_valid", {31'b0, out_valid}, 32'd0);
    drive(4'b0001, 1'b1, 5'd1, 5'd1, 5'd0, 12'd1);
    step();
    chk("ill_subi_valid", {31'b0, out_valid}, 32'd0);
    chk("ill_subi_err", {31'b0, err}, 32'd1);
    drive(4'b0000, 1'b0, 5'd1, 5'd2, 5'd3, 12'd0);
    step(); in_valid = 1'b0;
    chk("post_ill_instr", out_instr, 32'h003100B3);
    chk("post_ill_addr", {24'b0, out_addr}, 32'd0);
    chk("err_sticky", {31'b0, err}, 32'd1);
    step();
    do_clear();
    chk("err_cleared", {31'b0, err}, 32'd0);

    // four words fill DEPTH=4
    drive(4'b0111, 1'b0, 5'd4, 5'd5, 5'd6, 12'd0);
    step();
    chk("and_instr", out_instr, 32'h0062F233);
    chk("and_addr", {24'b0, out_addr}, 32'd0);
    drive(4'b0110, 1'b1, 5'd7, 5'd8, 5'd0, 12'hFFF);
    step();
    chk("ori_instr", out_instr, 32'hFFF46393);
    chk("ori_addr", {24'b0, out_addr}, 32'd1);
    drive(4'b0100, 1'b0, 5'd31, 5'd30, 5'd29, 12'd0);
    step();
    chk("xor_instr", out_instr, 32'h01DF4FB3);
    chk("xor_addr", {24'b0, out_addr}, 32'd2);
    chk("not_full_yet", {31'b0, full}, 32'd0);
    drive(4'b0101, 1'b1, 5'd9, 5'd10, 5'd0, 12'h01F);
    step();
    chk("srli_instr", out_instr, 32'h01F55493);
    chk("srli_addr", {24'b0, out_addr}, 32'd3);
    chk("full_set", {31'b0, full}, 32'd1);
    chk("full_in_ready", {31'b0, in_ready}, 32'd0);
    drive(4'b0000, 1'b1, 5'd1, 5'd0, 5'd0, 12'd7);
    step();
    chk("full_drain", {31'b0, out_valid}, 32'd0);
    chk("full_sticky", {31'b0, full}, 32'd1);
    in_valid = 1'b0;
    do_clear();
    chk("full_cleared", {31'b0, full}, 32'd0);
    drive(4'b0000, 1'b1, 5'd1, 5'd0, 5'd0, 12'd5);
    step(); in_valid = 1'b0;
    chk("wrap_addr", {24'b0, out_addr}, 32'd0);
    chk("wrap_instr", out_instr, 32'h00500093);
    step();

    // reset while a word is stalled
    out_ready = 1'b0;
    drive(4'b0011, 1'b0, 5'd1, 5'd2, 5'd3, 12'd0);
    step(); in_valid = 1'b0;
    chk("slt_instr", out_instr, 32'h003120B3);
    chk("slt_valid", {31'b0, out_valid}, 32'd1);
    #2 rst_n = 1'b0;
    #1 chk("midrst_valid", {31'b0, out_valid}, 32'd0);
    chk("midrst_instr", out_instr, 32'd0);
    step();
    rst_n = 1'b1;
    out_ready = 1'b1;
    step();
    chk("postrst_valid", {31'b0, out_valid}, 32'd0);
    chk("postrst_addr", {24'b0, out_addr}, 32'd0);
    drive(4'b0000, 1'b0, 5'd3, 5'd1, 5'd2, 12'd0);
    step(); in_valid = 1'b0;
    chk("postrst_cnt0", {24'b0, out_addr}, 32'd0);
    chk("postrst_word", out_instr, 32'h002081B3);
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
